// File: rtl/hub75_rx.sv
// HUB75 panel-side receiver: oversamples the scan interface, captures rows into a
// double-buffered column store, replays each latched row as a stream, and measures on-time.
module hub75_rx #(
  parameter  int N_BANKS    = 2,
  parameter  int N_ROWS     = 32,
  parameter  int N_COLS     = 64,
  parameter  int N_CHANS    = 3,
  parameter  int ON_W       = 16,
  localparam int LOG_N_ROWS = $clog2(N_ROWS),
  localparam int LOG_N_COLS = $clog2(N_COLS),
  localparam int DATA_W     = N_BANKS * N_CHANS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LOG_N_ROWS-1:0] hub75_addr,
  input  logic [DATA_W-1:0]     hub75_data,
  input  logic                  hub75_clk,
  input  logic                  hub75_le,
  input  logic                  hub75_blank,
  output logic [LOG_N_ROWS-1:0] out_row_addr,
  output logic [LOG_N_COLS-1:0] out_col_addr,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [ON_W-1:0]       on_len,
  output logic [LOG_N_ROWS-1:0] on_addr,
  output logic                  on_valid,
  output logic                  err_overrun,
  output logic                  err_len
);

  localparam logic [LOG_N_COLS:0]   COLS_FULL = (LOG_N_COLS + 1)'(N_COLS);
  localparam logic [LOG_N_COLS-1:0] LAST_COL  = LOG_N_COLS'(N_COLS - 1);
  localparam logic [ON_W-1:0]       ON_MAX    = '1;

  typedef struct packed {
    logic [LOG_N_ROWS-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic                  le;
    logic                  blank;
    logic                  sclk;
  } pins_t;

  typedef enum logic {IDLE, EMIT} state_t;

  pins_t pin_now, s1, s2, s3;
  logic  clk_rise, le_rise, blank_fall, blank_rise;

  assign pin_now = {hub75_addr, hub75_data, hub75_le, hub75_blank, hub75_clk};

  // s1/s2 synchronise; s3 and the registered edge pulses stay aligned with each other.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      s3         <= '0;
      s1.blank   <= 1'b1;
      s2.blank   <= 1'b1;
      s3.blank   <= 1'b1;
      clk_rise   <= 1'b0;
      le_rise    <= 1'b0;
      blank_fall <= 1'b0;
      blank_rise <= 1'b0;
    end else begin
      s1         <= pin_now;
      s2         <= s1;
      s3         <= s2;
      clk_rise   <= s2.sclk & ~s3.sclk;
      le_rise    <= s2.le & ~s3.le;
      blank_fall <= ~s2.blank & s3.blank;
      blank_rise <= s2.blank & ~s3.blank;
    end
  end

  state_t                state, state_nxt;
  logic [LOG_N_COLS:0]   shift_cnt;
  logic                  bank_sel;   // bank currently being captured; replay uses the other
  logic                  accept, last_col, latch_ok, cnt_full;
  logic                  wr_en, wr_bank, rd_bank;
  logic [LOG_N_COLS-1:0] wr_idx, rd_idx;
  logic [DATA_W-1:0]     mem [0:(2**(LOG_N_COLS + 1))-1];

  assign accept   = (state == EMIT) && out_ready;
  assign last_col = (out_col_addr == LAST_COL);
  assign latch_ok = le_rise && (state == IDLE);
  assign cnt_full = (shift_cnt == COLS_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: a default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (le_rise) state_nxt = EMIT;
      EMIT:    if (accept && last_col) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == EMIT);
    out_last  = (state == EMIT) && last_col;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_cnt    <= '0;
      bank_sel     <= 1'b0;
      out_row_addr <= '0;
      out_col_addr <= '0;
      err_len      <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      // A shift edge coincident with LE belongs to the new row.
      if (le_rise)
        shift_cnt <= clk_rise ? (LOG_N_COLS + 1)'(1) : '0;
      else if (clk_rise && !cnt_full)
        shift_cnt <= shift_cnt + 1'b1;

      if (latch_ok) begin
        bank_sel     <= ~bank_sel;
        out_row_addr <= s3.addr;
        out_col_addr <= '0;
        if (!cnt_full) err_len <= 1'b1;
      end else if (accept) begin
        out_col_addr <= last_col ? '0 : out_col_addr + 1'b1;
      end

      if (le_rise && (state == EMIT)) err_overrun <= 1'b1;
    end
  end

  // Writes always target the capture bank, reads the replay bank, so they never collide.
  assign wr_en   = clk_rise && (le_rise || !cnt_full);
  assign wr_bank = latch_ok ? ~bank_sel : bank_sel;
  assign wr_idx  = le_rise ? '0 : shift_cnt[LOG_N_COLS-1:0];
  assign rd_bank = latch_ok ? bank_sel : ~bank_sel;
  assign rd_idx  = latch_ok ? '0 :
                   (accept && !last_col) ? out_col_addr + 1'b1 : out_col_addr;

  // NOTE: the column store has no reset so it maps onto plain RAM; only its read register resets.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_idx}] <= s3.data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    out_data <= '0;
    else if (state_nxt == EMIT) out_data <= mem[{rd_bank, rd_idx}];
  end

  logic [ON_W-1:0] on_cnt;
  logic            seen_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      on_cnt    <= '0;
      seen_fall <= 1'b0;
      on_len    <= '0;
      on_addr   <= '0;
      on_valid  <= 1'b0;
    end else begin
      on_valid <= 1'b0;
      // The falling-edge cycle is already the first low cycle, so it counts as 1.
      if (blank_fall) begin
        on_cnt    <= ON_W'(1);
        seen_fall <= 1'b1;
      end else if (!s3.blank && (on_cnt != ON_MAX)) begin
        on_cnt <= on_cnt + 1'b1;
      end
      if (blank_rise && seen_fall) begin
        on_len   <= on_cnt;
        on_addr  <= s3.addr;
        on_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hub75_rx.sv
// Randomised self-checking bench for hub75_rx: a row/bank model predicts every streamed
// beat, error flag and on-time measurement from the pin-level activity the bench drives.
module tb_hub75_rx;
  localparam int N_COLS = 64;
  localparam int LR     = 5;
  localparam int LC     = 6;
  localparam int DW     = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [LR-1:0] hub75_addr = '0;
  logic [DW-1:0] hub75_data = '0;
  logic          hub75_clk = 1'b0, hub75_le = 1'b0, hub75_blank = 1'b1;
  logic          out_ready = 1'b1;

  logic [LR-1:0] out_row_addr, on_addr, out_row_addr8, on_addr8;
  logic [LC-1:0] out_col_addr, out_col_addr8;
  logic [DW-1:0] out_data, out_data8;
  logic          out_valid, out_last, on_valid, err_overrun, err_len;
  logic          out_valid8, out_last8, on_valid8, err_overrun8, err_len8;
  logic [15:0]   on_len;
  logic [7:0]    on_len8;

  always #5 clk = ~clk;

  hub75_rx dut (
    .clk(clk), .rst(rst), .hub75_addr(hub75_addr), .hub75_data(hub75_data),
    .hub75_clk(hub75_clk), .hub75_le(hub75_le), .hub75_blank(hub75_blank),
    .out_row_addr(out_row_addr), .out_col_addr(out_col_addr), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .on_len(on_len), .on_addr(on_addr), .on_valid(on_valid),
    .err_overrun(err_overrun), .err_len(err_len)
  );

  hub75_rx #(.ON_W(8)) dut8 (
    .clk(clk), .rst(rst), .hub75_addr(hub75_addr), .hub75_data(hub75_data),
    .hub75_clk(hub75_clk), .hub75_le(hub75_le), .hub75_blank(hub75_blank),
    .out_row_addr(out_row_addr8), .out_col_addr(out_col_addr8), .out_data(out_data8),
    .out_valid(out_valid8), .out_ready(out_ready), .out_last(out_last8),
    .on_len(on_len8), .on_addr(on_addr8), .on_valid(on_valid8),
    .err_overrun(err_overrun8), .err_len(err_len8)
  );

  typedef struct packed {
    logic [LR-1:0] row;
    logic [LC-1:0] col;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  // Reference model: two banks of column data, capture pointer, shift count, pending beats.
  logic [DW-1:0] bank_m [2][N_COLS];
  int            cap_m = 0;
  int            cnt_m = 0;
  bit            exp_err_len = 1'b0, exp_err_ovr = 1'b0;
  beat_t         exp_q[$];

  int            n_pass = 0, n_chk = 0;
  longint        cyc = 0, latch_cyc = -100;
  int            rmode = 0;
  int            beats = 0, valid_cycles = 0;
  logic [DW-1:0] obs [N_COLS];
  int            on_len_q[$], on_addr_q[$], on_len8_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_shift(input logic [DW-1:0] d);
    if (cnt_m < N_COLS) begin
      bank_m[cap_m][cnt_m] = d;
      cnt_m++;
    end
  endtask

  task automatic model_latch(input logic [LR-1:0] addr);
    beat_t b;
    if (exp_q.size() > 0) begin
      exp_err_ovr = 1'b1;
    end else begin
      if (cnt_m != N_COLS) exp_err_len = 1'b1;
      for (int c = 0; c < N_COLS; c++) begin
        b.row  = addr;
        b.col  = LC'(c);
        b.last = (c == N_COLS - 1);
        b.data = bank_m[cap_m][c];
        exp_q.push_back(b);
      end
      cap_m = 1 - cap_m;
    end
    cnt_m = 0;
  endtask

  task automatic shift_col(input logic [DW-1:0] d);
    model_shift(d);
    hub75_data = d;
    hub75_clk  = 1'b1;
    tick(2);
    hub75_clk  = 1'b0;
    tick(2);
  endtask

  // mode 0: data = column index, 1: data = 63 - column, 2: random
  task automatic shift_row(input int n, input int mode);
    logic [DW-1:0] d;
    for (int c = 0; c < n; c++) begin
      if (mode == 0)      d = DW'(c);
      else if (mode == 1) d = DW'(63 - c);
      else                d = DW'($urandom);
      shift_col(d);
    end
  endtask

  task automatic pulse_le(input logic [LR-1:0] addr);
    hub75_addr = addr;
    model_latch(addr);
    latch_cyc  = cyc;
    hub75_le   = 1'b1;
    tick(2);
    hub75_le   = 1'b0;
    tick(2);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 4000) begin
      tick(1);
      k++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
    tick(4);
  endtask

  task automatic blank_pulse(input int len, input logic [LR-1:0] addr);
    int k;
    hub75_addr  = addr;
    tick(2);
    hub75_blank = 1'b0;
    tick(len);
    hub75_blank = 1'b1;
    k = 0;
    while (on_len_q.size() == 0 && k < 20) begin
      tick(1);
      k++;
    end
    tick(3);
    check("on_pulse_count", on_len_q.size(), 1);
    check("on8_pulse_count", on_len8_q.size(), 1);
    if (on_len_q.size() > 0) begin
      check("on_len", on_len_q[0], len);
      check("on_addr", on_addr_q[0], addr);
    end
    if (on_len8_q.size() > 0) check("on_len_w8", on_len8_q[0], (len > 255) ? 255 : len);
    on_len_q.delete();
    on_addr_q.delete();
    on_len8_q.delete();
    tick(4);
  endtask

  // Ready pattern: 0 always high, 1 toggling, 2 random, 3 held low.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Single compare process: every beat against the model, plus on-time strobe capture.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (exp_q.size() == 0) begin
          check("idle_valid", out_valid, 0);
        end else begin
          if (cyc >= latch_cyc + 4) check("valid_by_latency", out_valid, 1);
          if (out_valid) begin
            check("beat", {out_row_addr, out_col_addr, out_last, out_data}, exp_q[0]);
            valid_cycles++;
            if (out_ready) begin
              obs[out_col_addr] = out_data;
              beats++;
              void'(exp_q.pop_front());
            end
          end
        end
        if (on_valid) begin
          on_len_q.push_back(int'(on_len));
          on_addr_q.push_back(int'(on_addr));
        end
        if (on_valid8) on_len8_q.push_back(int'(on_len8));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < N_COLS; c++) bank_m[b][c] = '0;

    // Reset state
    tick(3);
    check("rst_stream", {out_valid, out_last, out_col_addr, out_row_addr, out_data}, 0);
    check("rst_on", {on_len, on_addr, on_valid, err_overrun, err_len}, 0);
    rst = 1'b0;
    tick(8);
    check("no_false_blank_edge", on_len_q.size(), 0);
    check("idle_after_rst", out_valid, 0);

    // Row transfer with exact latency
    rmode = 0;
    beats = 0;
    shift_row(64, 0);
    hub75_addr = 5;
    model_latch(5);
    latch_cyc  = cyc;
    hub75_le   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("latency_not_early", out_valid, 0);
    @(posedge clk);
    #1;
    check("latency_on_time", out_valid, 1);
    check("first_beat_literal", {out_row_addr, out_col_addr, out_data}, {5'd5, 6'd0, 6'd0});
    hub75_le = 1'b0;
    tick(2);
    drain("row_drained");
    check("row_beats", beats, 64);
    check("row_last_data", obs[63], 63);
    check("row_err_len", err_len, 0);
    check("row_err_ovr", err_overrun, 0);

    // Backpressure: ready toggling
    beats = 0;
    valid_cycles = 0;
    shift_row(64, 0);
    rmode = 1;
    pulse_le(5);
    drain("bp_drained");
    rmode = 0;
    check("bp_beats", beats, 64);
    check("bp_cycles", (valid_cycles == 127 || valid_cycles == 128), 1);

    // Short row: last 4 columns come from the bank's earlier contents
    beats = 0;
    shift_row(60, 1);
    pulse_le(7);
    drain("short_drained");
    check("short_beats", beats, 64);
    check("short_err_len", err_len, exp_err_len);
    check("short_err_len_lit", err_len, 1);
    check("short_col0", obs[0], 63);
    check("short_col59", obs[59], 4);
    check("short_col60", obs[60], 60);
    check("short_col63", obs[63], 63);

    // Overrun: second LE while the first row is stalled
    beats = 0;
    rmode = 3;
    tick(2);
    shift_row(64, 2);
    pulse_le(3);
    check("ovr_before", err_overrun, 0);
    shift_row(64, 0);
    pulse_le(4);
    tick(4);
    check("ovr_flag", err_overrun, exp_err_ovr);
    check("ovr_flag_lit", err_overrun, 1);
    check("ovr_stalled", out_valid, 1);
    rmode = 0;
    drain("ovr_drained");
    check("ovr_beats", beats, 64);

    // On-time measurement
    blank_pulse(300, 9);
    for (int i = 0; i < 3; i++) blank_pulse($urandom_range(2, 600), LR'($urandom));

    // Reset in the middle of a stream
    beats = 0;
    shift_row(64, 2);
    rmode = 2;
    pulse_le(11);
    begin
      int k;
      k = 0;
      while (beats < 10 && k < 1000) begin
        tick(1);
        k++;
      end
      check("reached_beat10", beats >= 10, 1);
    end
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_stream", {out_valid, out_last, out_col_addr, out_row_addr, out_data}, 0);
    check("midrst_on", {on_len, on_addr, on_valid, err_overrun, err_len}, 0);
    exp_q.delete();
    cap_m = 0;
    cnt_m = 0;
    exp_err_len = 1'b0;
    exp_err_ovr = 1'b0;
    rmode = 0;
    tick(3);
    rst = 1'b0;
    tick(3);
    beats = 0;
    shift_row(64, 2);
    pulse_le(21);
    drain("post_rst_drained");
    check("post_rst_beats", beats, 64);
    check("post_rst_err_len", err_len, 0);

    // Randomised rows, some short or over-long
    for (int i = 0; i < 6; i++) begin
      int len;
      len = (i == 0) ? 64 : $urandom_range(58, 68);
      shift_row(len, 2);
      rmode = $urandom_range(0, 2);
      pulse_le(LR'($urandom));
      drain("rand_drained");
      if (i == 0) check("rand_full_no_err", err_len, 0);
    end
    check("rand_err_len", err_len, exp_err_len);
    check("rand_err_ovr", err_overrun, exp_err_ovr);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- Synthesizable receiver for the HUB75 panel-side protocol, i.e. the far end of the link driven by the hub75_top scan engine.
- Oversamples hub75_clk/le/blank/addr/data in the system clock domain and captures each shifted row into a double-buffered column store.
- On every latch pulse it replays the row as a valid/ready column stream, and it measures each display-on (blank low) interval.
- Used as an on-chip loopback checker and as a self-checking monitor in panel benches.

Parameters:
- N_BANKS, 2, number of banks (parallel data groups).
- N_ROWS, 32, rows per bank; LOG_N_ROWS = $clog2(N_ROWS).
- N_COLS, 64, columns per row; LOG_N_COLS = $clog2(N_COLS).
- N_CHANS, 3, colour channels per bank; DATA_W = N_BANKS*N_CHANS.
- ON_W, 16, width of the on-time counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- hub75_addr  in  LOG_N_ROWS  row address from the driver.
- hub75_data  in  DATA_W  serial column data.
- hub75_clk  in  1  shift clock; data is sampled on its rising edge.
- hub75_le  in  1  latch enable.
- hub75_blank  in  1  output blank; 1 = LEDs off.
- out_row_addr  out  LOG_N_ROWS  row address captured at the latch.
- out_col_addr  out  LOG_N_COLS  column index of out_data.
- out_data  out  DATA_W  column data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  marks column N_COLS-1.
- on_len  out  ON_W  clk cycles blank was low.
- on_addr  out  LOG_N_ROWS  hub75_addr sampled at the blank rising edge.
- on_valid  out  1  1-cycle strobe when on_len/on_addr update.
- err_overrun  out  1  sticky; LE arrived while the previous row was still streaming.
- err_len  out  1  sticky; latched shift count was not N_COLS.

Behaviour:
- Input synchronisation:
  - All hub75_* inputs pass through a 2-FF synchroniser, plus a third register used for edge detection.
  - Data and addr use the same pipeline depth as hub75_clk, so sampled data is aligned with the detected edge.
  - Inputs must hold each level for at least 2 clk periods; faster toggling is out of scope.
- Capture:
  - On each synchronised hub75_clk rising edge, write the data to the capture bank at index shift_cnt, then increment shift_cnt.
  - shift_cnt saturates at N_COLS; writes at saturation are discarded.
  - Column 0 is the first column shifted in.
- Latch (synchronised hub75_le rising edge):
  - If the FSM is IDLE: swap capture/replay banks; register hub75_addr into out_row_addr; set err_len if shift_cnt != N_COLS; clear shift_cnt; go to EMIT.
  - If the FSM is in EMIT: set err_overrun; do not swap; clear shift_cnt. The captured row is dropped.
  - A hub75_clk edge in the same cycle as the LE edge is counted into the new (post-clear) row.
- FSM states:
  - IDLE: out_valid=0.
  - EMIT: out_valid=1 with out_col_addr = 0..N_COLS-1. Advance on out_valid & out_ready. out_last=1 when out_col_addr == N_COLS-1. The accepted last beat returns the FSM to IDLE.
  - out_data/out_col_addr/out_last must hold stable while out_valid & !out_ready.
- Latency:
  - out_valid rises exactly 4 clk edges after the edge that first samples hub75_le=1: 2 sync, 1 edge detect, 1 FSM register.
  - Ready held high gives 1 column per cycle, so N_COLS cycles per row.
- On-time measurement:
  - On the synchronised blank falling edge, clear the counter.
  - Increment every cycle while blank is low, saturating at 2^ON_W-1.
  - On the synchronised blank rising edge, load on_len and on_addr, and pulse on_valid for 1 cycle.
  - A blank rising edge with no prior falling edge since reset is ignored.
- Reset (asynchronous, any state, including mid-EMIT):
  - FSM → IDLE, shift_cnt=0, bank select=0.
  - All outputs 0: out_valid, out_last, out_col_addr, out_row_addr, out_data, on_len, on_addr, on_valid, err_overrun, err_len.
  - Synchroniser registers reset to 0, except hub75_blank, which resets to 1 so reset release produces no false edge.
- Memories: 2 banks × N_COLS × DATA_W, inferable as distributed or block RAM with 1-cycle read latency. The read address is prefetched so that out_data is valid together with out_valid.

Test Plan:
- Row transfer: shift 64 columns with data = col[5:0], addr=5, then pulse LE; ready=1 → 64 beats with out_data = 0..63, out_row_addr=5, out_last only on col 63, first beat 4 clks after LE, no errors.
- Backpressure: same row with out_ready toggling 1/0 each cycle → 64 beats, each held stable while stalled, completes in 128 cycles.
- Short row: shift 60 columns, then LE → err_len=1, 64 beats emitted; columns 60..63 carry the previous row's bank contents.
- Overrun: ready=0 after the first LE, shift a full row, second LE → err_overrun=1; after ready=1 the stream shows the first row only.
- On-time: blank low for 300 clks with addr=9 → on_valid pulse, on_len=300, on_addr=9. With ON_W=8 the same stimulus gives on_len=255.
- Reset mid-EMIT: assert rst at beat 10 → all outputs 0 immediately; after release, a new row streams correctly from col 0.
